datamem_param: RTL and testbench



---
 rtl/datamem_param.sv | 155 +++++++++++++++
 tb/tb_datamem_param.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/datamem_param.sv
// Parametrised single-port data memory: valid/ready requests, byte strobes, one-cycle read
// response and out-of-range flagging. Define DATAMEM_CLEAR_EN to zero-fill the array after reset.
module datamem_param #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_we_i,
    input  logic [DATA_WIDTH/8-1:0] req_be_i,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    output logic                    rsp_valid_o,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic                    busy_o
);
    localparam int NUM_LANES = DATA_WIDTH / 8;
    localparam int BL        = $clog2(NUM_LANES);
    localparam int HI        = DEPTH_LOG2 + BL;
    localparam int DEPTH     = 1 << DEPTH_LOG2;

    logic                  ready_q;
    logic                  busy_q;
    logic                  rsp_valid_q;
    logic                  rsp_valid_d;
    logic                  rsp_err_q;
    logic                  rsp_err_d;
    logic                  accept;
    logic                  out_of_range;
    logic                  wr_en;
    logic                  rd_en;
    logic                  clr_we;
    logic [DEPTH_LOG2-1:0] clr_index;
    logic [DEPTH_LOG2-1:0] req_index;
    logic [DEPTH_LOG2-1:0] mem_index;
    logic [DATA_WIDTH-1:0] rdata_raw;

    assign req_index = req_addr_i[HI-1:BL];

    generate
        if (ADDR_WIDTH > HI) begin : g_oor
            assign out_of_range = |req_addr_i[ADDR_WIDTH-1:HI];
        end else begin : g_no_oor
            assign out_of_range = 1'b0;
        end
        // Byte-offset bits carry no meaning: lane selection comes from req_be_i alone.
        if (BL > 0) begin : g_low_bits
            logic unused_addr_low;
            assign unused_addr_low = ^req_addr_i[BL-1:0];
        end
    endgenerate

    assign accept = req_valid_i & ready_q;
    assign wr_en  = accept & req_we_i & ~out_of_range;
    assign rd_en  = accept & ~req_we_i & ~out_of_range;

`ifdef DATAMEM_CLEAR_EN
    typedef enum logic {CLEAR, RUN} state_t;
    state_t                state_q;
    logic [DEPTH_LOG2-1:0] clr_cnt_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            case (state_q)
                CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                    if (&clr_cnt_q) begin
                        state_q <= RUN;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign clr_we    = (state_q == CLEAR);
    assign clr_index = clr_cnt_q;
`else
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    assign busy_q    = 1'b0;
    assign clr_we    = 1'b0;
    assign clr_index = '0;
`endif

    // The clear sweep and requests never overlap, so they share the single write port.
    assign mem_index = clr_we ? clr_index : req_index;

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] rd_q;
            logic       lane_we;
            logic [7:0] lane_wdata;

            assign lane_we    = clr_we | (wr_en & req_be_i[gi]);
            assign lane_wdata = clr_we ? 8'h00 : req_wdata_i[gi*8 +: 8];

            always_ff @(posedge clk_i) begin
                if (lane_we) begin
                    mem[mem_index] <= lane_wdata;
                end
            end

            always_ff @(posedge clk_i) begin
                if (rd_en) begin
                    rd_q <= mem[req_index];
                end
            end

            assign rdata_raw[gi*8 +: 8] = rd_q;
        end
    endgenerate

    assign rsp_valid_d = accept & (~req_we_i | out_of_range);
    assign rsp_err_d   = accept & out_of_range;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Array output register has no reset; gating keeps the data bus at zero outside good reads.
    assign rsp_rdata_o = (rsp_valid_q & ~rsp_err_q) ? rdata_raw : '0;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign req_ready_o = ready_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_datamem_param.sv
// Bench for datamem_param (DATA_WIDTH=32, DEPTH_LOG2=4): directed table, reset/clear
// sequences and random traffic against a word-array reference model.
module tb_datamem_param;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DL    = 4;
    localparam int DEPTH = 16;
`ifdef DATAMEM_CLEAR_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic [3:0]    req_be = '0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          req_ready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          busy;

    datamem_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH_LOG2(DL)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_be_i    (req_be),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [31:0] model_mem   [DEPTH];
    bit   [3:0]  model_known [DEPTH];

    logic        got_valid;
    logic        got_err;
    logic [31:0] got_rdata;

    typedef struct {
        bit          v;
        bit          we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wd;
        bit          ev;
        bit          ee;
        logic [31:0] er;
    } vec_t;

    localparam int NTBL = 13;
    vec_t tbl [NTBL];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic bit exp_ready();
        return CLEAR_EN ? (cyc >= DEPTH) : (cyc >= 1);
    endfunction

    function automatic bit exp_busy();
        return CLEAR_EN && (cyc < DEPTH);
    endfunction

    // One clock of traffic: predict from the model, step the clock, compare, update model.
    task automatic do_req(input bit v, input bit we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wd, input string tag);
        bit          acc;
        bit          oor;
        bit          ev;
        bit          ee;
        bit          known;
        int          idx;
        logic [31:0] er;
        req_valid = v;
        req_we    = we;
        req_be    = be;
        req_addr  = addr;
        req_wdata = wd;
        acc   = v && exp_ready();
        oor   = (addr >> 6) != 0;
        idx   = int'(addr[5:2]);
        ev    = acc && (!we || oor);
        ee    = acc && oor;
        er    = oor ? 32'h0 : model_mem[idx];
        known = oor || (model_known[idx] == 4'hF);
        if (acc && we && !oor) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) begin
                    model_mem[idx][k*8 +: 8] = wd[k*8 +: 8];
                    model_known[idx][k]      = 1'b1;
                end
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        chk({tag, " rsp_valid"}, {31'b0, rsp_valid}, {31'b0, ev});
        if (ev) chk({tag, " rsp_err"}, {31'b0, rsp_err}, {31'b0, ee});
        if (ev && known) chk({tag, " rsp_rdata"}, rsp_rdata, er);
        chk({tag, " req_ready"}, {31'b0, req_ready}, {31'b0, exp_ready()});
        chk({tag, " busy"}, {31'b0, busy}, {31'b0, exp_busy()});
        $display("req %s v=%0d we=%0d be=%h addr=%h wd=%h -> rsp_valid=%0d err=%0d rdata=%h",
                 tag, v, we, be, addr, wd, rsp_valid, rsp_err, rsp_rdata);
        got_valid = rsp_valid;
        got_err   = rsp_err;
        got_rdata = rsp_rdata;
        req_valid = 1'b0;
    endtask

    task automatic apply_reset(input int cycles, input string tag);
        reset     = 1'b1;
        req_valid = 1'b0;
        #1;
        chk({tag, " reset rsp_valid"}, {31'b0, rsp_valid}, 32'h0);
        chk({tag, " reset rsp_err"}, {31'b0, rsp_err}, 32'h0);
        chk({tag, " reset rsp_rdata"}, rsp_rdata, 32'h0);
        chk({tag, " reset req_ready"}, {31'b0, req_ready}, 32'h0);
        chk({tag, " reset busy"}, {31'b0, busy}, {31'b0, CLEAR_EN});
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i]   = 32'h0;
            model_known[i] = CLEAR_EN ? 4'hF : 4'h0;
        end
        $display("reset %s released", tag);
    endtask

    initial begin
        tbl[0]  = '{1, 1, 4'hF, 32'h08, 32'hDEADBEEF, 0, 0, 32'h0};
        tbl[1]  = '{1, 1, 4'h1, 32'h08, 32'h000000AA, 0, 0, 32'h0};
        tbl[2]  = '{1, 0, 4'h0, 32'h08, 32'h0,        1, 0, 32'hDEADBEAA};
        tbl[3]  = '{0, 0, 4'h0, 32'h0,  32'h0,        0, 0, 32'h0};
        tbl[4]  = '{1, 1, 4'hF, 32'h10, 32'h11223344, 0, 0, 32'h0};
        tbl[5]  = '{1, 0, 4'hF, 32'h10, 32'h0,        1, 0, 32'h11223344};
        tbl[6]  = '{1, 1, 4'hF, 32'h00, 32'hCAFEF00D, 0, 0, 32'h0};
        tbl[7]  = '{1, 0, 4'h0, 32'h40, 32'h0,        1, 1, 32'h0};
        tbl[8]  = '{1, 1, 4'hF, 32'h40, 32'hFFFFFFFF, 1, 1, 32'h0};
        tbl[9]  = '{1, 0, 4'h0, 32'h00, 32'h0,        1, 0, 32'hCAFEF00D};
        tbl[10] = '{1, 1, 4'h0, 32'h13, 32'h55555555, 0, 0, 32'h0};
        tbl[11] = '{1, 0, 4'h0, 32'h11, 32'h0,        1, 0, 32'h11223344};
        tbl[12] = '{1, 0, 4'h0, 32'h0B, 32'h0,        1, 0, 32'hDEADBEAA};

        apply_reset(2, "initial");

        // Requests during the clear window must be ignored; afterwards 0x3C reads zero.
        while (!exp_ready()) do_req(1'b1, 1'b1, 4'hF, 32'h3C, 32'hFFFFFFFF, "held");
        if (CLEAR_EN) begin
            do_req(1'b1, 1'b0, 4'h0, 32'h3C, 32'h0, "rd3C");
            chk("clear rd3C valid", {31'b0, got_valid}, 32'h1);
            chk("clear rd3C data", got_rdata, 32'h0);
        end

        for (int i = 0; i < NTBL; i++) begin
            do_req(tbl[i].v, tbl[i].we, tbl[i].be, tbl[i].addr, tbl[i].wd, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d valid", i), {31'b0, got_valid}, {31'b0, tbl[i].ev});
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d err", i), {31'b0, got_err}, {31'b0, tbl[i].ee});
                chk($sformatf("tbl%0d data", i), got_rdata, tbl[i].er);
            end
        end

        // A pending read response must vanish as soon as reset asserts.
        do_req(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, "pre_rst");
        chk("pre_rst valid", {31'b0, got_valid}, 32'h1);
        apply_reset(2, "run");

        if (CLEAR_EN) begin
            for (int i = 0; i < 7; i++) do_req(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, "clr");
            apply_reset(2, "midclear");
            while (!exp_ready()) do_req(1'b1, 1'b1, 4'hF, 32'h04, 32'h12345678, "held2");
            for (int i = 0; i < DEPTH; i++) do_req(1'b1, 1'b0, 4'h0, 32'(i * 4), 32'h0, "zero");
        end else begin
            while (!exp_ready()) do_req(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, "idle");
        end

        for (int i = 0; i < DEPTH; i++) do_req(1'b1, 1'b1, 4'hF, 32'(i * 4), $urandom, "init");

        for (int n = 0; n < 300; n++) begin
            int          r;
            logic [31:0] a;
            r = $urandom_range(0, 9);
            if (r == 0)      a = $urandom | 32'h8000_0000;
            else if (r == 1) a = 32'h40 + $urandom_range(0, 63);
            else             a = $urandom_range(0, 63);
            do_req($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)), 4'($urandom),
                   a, $urandom, $sformatf("rnd%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
